seg_serial_tx: RTL and testbench

//  Serial transmitter for the board's chained shift-register 7-segment display.

---
 rtl/seg_serial_tx.sv | 133 +++++++++++++
 tb/tb_seg_serial_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg_serial_tx.sv
// Serial transmitter for the chained shift-register 7-segment display.
// Shifts a WIDTH-bit frame out on seg_clk/seg_dout, then pulses seg_le to latch it.
module seg_serial_tx #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             seg_clk,
    output logic             seg_dout,
    output logic             seg_le,
    output logic             seg_clrn
);

    localparam int unsigned DW = $clog2(CLK_DIV + 1);
    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shadow, shadow_n;
    logic [DW-1:0]    div, div_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic             busy_n, done_n, seg_clk_n, seg_dout_n, seg_le_n;

    // The shadow register is shifted so the bit on the wire is always at its head.
    function automatic logic head(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    always_comb begin
        state_n   = state;
        shadow_n  = shadow;
        div_n     = div;
        bit_cnt_n = bit_cnt;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    shadow_n  = data;
                    div_n     = '0;
                    bit_cnt_n = '0;
                    state_n   = SHIFT_LO;
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT_LO: begin
                if (div == DIV_LAST) begin
                    div_n   = '0;
                    state_n = SHIFT_HI;
                end else begin
                    div_n = div + DW'(1);
                end
            end
            SHIFT_HI: begin
                if (div == DIV_LAST) begin
                    div_n     = '0;
                    bit_cnt_n = bit_cnt + BW'(1);
                    if (bit_cnt == BIT_LAST) begin
                        state_n = LATCH;
                    end else begin
                        shadow_n = advance(shadow);
                        state_n  = SHIFT_LO;
                    end
                end else begin
                    div_n = div + DW'(1);
                end
            end
            LATCH: begin
                if (div == DIV_LAST) begin
                    div_n   = '0;
                    state_n = DONE;
                end else begin
                    div_n = div + DW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        busy_n     = (state_n == SHIFT_LO) || (state_n == SHIFT_HI) || (state_n == LATCH);
        done_n     = (state_n == DONE);
        seg_clk_n  = (state_n == SHIFT_HI);
        seg_le_n   = (state_n == LATCH);
        seg_dout_n = ((state_n == SHIFT_LO) || (state_n == SHIFT_HI)) ? head(shadow_n) : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shadow   <= '0;
            div      <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            seg_clk  <= 1'b0;
            seg_dout <= 1'b0;
            seg_le   <= 1'b0;
            seg_clrn <= 1'b0;
        end else begin
            state    <= state_n;
            shadow   <= shadow_n;
            div      <= div_n;
            bit_cnt  <= bit_cnt_n;
            busy     <= busy_n;
            done     <= done_n;
            seg_clk  <= seg_clk_n;
            seg_dout <= seg_dout_n;
            seg_le   <= seg_le_n;
            seg_clrn <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_serial_tx.sv
// Bench for seg_serial_tx: two instances (64/2/MSB-first and 64/1/LSB-first),
// frames rebuilt from the serial pins and compared against the captured data.
module tb_seg_serial_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [63:0] data_a, data_b;
    logic        busy_a, done_a, seg_clk_a, seg_dout_a, seg_le_a, seg_clrn_a;
    logic        busy_b, done_b, seg_clk_b, seg_dout_b, seg_le_b, seg_clrn_b;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned done_cnt_a = 0;
    int unsigned le_cnt_a   = 0;
    bit          q_a[$];
    bit          q_b[$];

    always #5 clk = ~clk;

    seg_serial_tx #(.WIDTH(64), .CLK_DIV(2), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .data(data_a),
        .busy(busy_a), .done(done_a), .seg_clk(seg_clk_a), .seg_dout(seg_dout_a),
        .seg_le(seg_le_a), .seg_clrn(seg_clrn_a)
    );

    seg_serial_tx #(.WIDTH(64), .CLK_DIV(1), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .data(data_b),
        .busy(busy_b), .done(done_b), .seg_clk(seg_clk_b), .seg_dout(seg_dout_b),
        .seg_le(seg_le_b), .seg_clrn(seg_clrn_b)
    );

    // What the display chain sees: one bit per seg_clk rising edge.
    always @(posedge seg_clk_a) q_a.push_back(seg_dout_a);
    always @(posedge seg_clk_b) q_b.push_back(seg_dout_b);

    always @(negedge clk) begin
        if (done_a === 1'b1) done_cnt_a++;
        if (seg_le_a === 1'b1) le_cnt_a++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int unsigned sel, input logic s, input logic [63:0] d);
        if (sel == 0) begin start_a = s; data_a = d; end
        else          begin start_b = s; data_b = d; end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Caller raises start at a negedge; the next posedge is E0. Frame length,
    // latch width and bit order come straight from the frame rules.
    task automatic watch(input int unsigned sel, input logic [63:0] exp, input int unsigned cd,
                         input bit msb, input string tag, input bit scramble,
                         input bit chain, input logic [63:0] nxt);
        int unsigned busy_n = 0, le_n = 0, ovl = 0, done_idx = 0, exp_busy, qs;
        logic [63:0] rebuilt = '0;
        logic bz, dn, sc, le;
        exp_busy = 2 * cd * 64 + cd;
        if (sel == 0) q_a.delete(); else q_b.delete();
        @(posedge clk);
        #1;
        if (!scramble) set_in(sel, 1'b0, 64'h0);
        for (int unsigned k = 1; k <= exp_busy + 20; k++) begin
            @(negedge clk);
            if (scramble) set_in(sel, 1'b1, (k % 2 == 1) ? {64{1'b1}} : rnd64());
            if (sel == 0) {bz, dn, sc, le} = {busy_a, done_a, seg_clk_a, seg_le_a};
            else          {bz, dn, sc, le} = {busy_b, done_b, seg_clk_b, seg_le_b};
            if (bz === 1'b1) busy_n++;
            if (le === 1'b1) le_n++;
            if (le === 1'b1 && sc === 1'b1) ovl++;
            if (dn === 1'b1) begin
                done_idx = k;
                if (chain) set_in(sel, 1'b1, nxt); else set_in(sel, 1'b0, 64'h0);
                break;
            end
        end
        qs = (sel == 0) ? q_a.size() : q_b.size();
        for (int unsigned i = 0; i < qs && i < 64; i++)
            rebuilt[msb ? 63 - i : i] = (sel == 0) ? q_a[i] : q_b[i];
        check({tag, "/rises"}, 64'(qs), 64'd64);
        check({tag, "/bits"}, rebuilt, exp);
        check({tag, "/busy_cycles"}, 64'(busy_n), 64'(exp_busy));
        check({tag, "/le_cycles"}, 64'(le_n), 64'(cd));
        check({tag, "/le_clk_overlap"}, 64'(ovl), 64'd0);
        check({tag, "/done_at"}, 64'(done_idx), 64'(exp_busy + 1));
        if (!chain) begin
            @(negedge clk);
            if (sel == 0) {bz, dn} = {busy_a, done_a}; else {bz, dn} = {busy_b, done_b};
            check({tag, "/after_done"}, {62'd0, bz, dn}, 64'd0);
        end
    endtask

    initial begin
        logic [63:0] d0;
        int unsigned snap_done, snap_le;
        set_in(0, 1'b0, 64'h0);
        set_in(1, 1'b0, 64'h0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_outs_a", {58'd0, busy_a, done_a, seg_clk_a, seg_dout_a, seg_le_a, seg_clrn_a}, 64'd0);
        check("reset_outs_b", {58'd0, busy_b, done_b, seg_clk_b, seg_dout_b, seg_le_b, seg_clrn_b}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("clrn_release", {62'd0, seg_clrn_a, seg_clrn_b}, 64'b11);
        repeat (5) @(negedge clk);
        check("idle_busy", {62'd0, busy_a, busy_b}, 64'd0);

        // Asynchronous reset at a random point mid-frame, away from any edge.
        @(negedge clk);
        set_in(0, 1'b1, rnd64());
        @(negedge clk);
        set_in(0, 1'b0, 64'h0);
        repeat ($urandom_range(10, 200)) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_outs", {58'd0, busy_a, done_a, seg_clk_a, seg_dout_a, seg_le_a, seg_clrn_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("clrn_after_edge", {63'd0, seg_clrn_a}, 64'd1);
        snap_done = done_cnt_a;
        repeat (10) @(negedge clk);
        check("idle_after_reset", {62'd0, busy_a, done_a}, 64'd0);
        check("no_done_after_reset", 64'(done_cnt_a - snap_done), 64'd0);

        @(negedge clk);
        set_in(0, 1'b1, 64'h8000_0000_0000_0001);
        watch(0, 64'h8000_0000_0000_0001, 2, 1'b1, "single", 1'b0, 1'b0, 64'h0);
        check("single/first_bit", {63'd0, q_a[0]}, 64'd1);

        @(negedge clk);
        set_in(0, 1'b1, 64'h0123_4567_89AB_CDEF);
        watch(0, 64'h0123_4567_89AB_CDEF, 2, 1'b1, "shadow", 1'b1, 1'b0, 64'h0);

        d0 = rnd64();
        snap_done = done_cnt_a;
        @(negedge clk);
        set_in(0, 1'b1, d0);
        watch(0, d0, 2, 1'b1, "b2b_first", 1'b0, 1'b1, 64'hA5A5_A5A5_5A5A_5A5A);
        watch(0, 64'hA5A5_A5A5_5A5A_5A5A, 2, 1'b1, "b2b_second", 1'b0, 1'b0, 64'h0);
        check("b2b_done_count", 64'(done_cnt_a - snap_done), 64'd2);

        // Abandon a frame after 37 bits have gone out.
        q_a.delete();
        @(negedge clk);
        set_in(0, 1'b1, rnd64());
        @(posedge clk);
        #1 set_in(0, 1'b0, 64'h0);
        for (int unsigned k = 0; k < 2000 && q_a.size() < 37; k++) @(negedge clk);
        check("abort/bits_sent", 64'(q_a.size()), 64'd37);
        snap_done = done_cnt_a;
        snap_le   = le_cnt_a;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("abort/no_done", 64'(done_cnt_a - snap_done), 64'd0);
        check("abort/no_le", 64'(le_cnt_a - snap_le), 64'd0);
        check("abort/idle", {63'd0, busy_a}, 64'd0);
        d0 = rnd64();
        @(negedge clk);
        set_in(0, 1'b1, d0);
        watch(0, d0, 2, 1'b1, "abort/fresh", 1'b0, 1'b0, 64'h0);

        @(negedge clk);
        set_in(1, 1'b1, 64'h1);
        watch(1, 64'h1, 1, 1'b0, "lsb_div1", 1'b0, 1'b0, 64'h0);
        check("lsb_div1/first_bit", {63'd0, q_b[0]}, 64'd1);

        for (int unsigned n = 0; n < 4; n++) begin
            d0 = rnd64();
            @(negedge clk);
            set_in(0, 1'b1, d0);
            watch(0, d0, 2, 1'b1, "rand_a", 1'b0, 1'b0, 64'h0);
            d0 = rnd64();
            @(negedge clk);
            set_in(1, 1'b1, d0);
            watch(1, d0, 1, 1'b0, "rand_b", 1'b0, 1'b0, 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
